// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the W-stage slice.
//   XLEN           : datapath width
//   LOAD_*         : funct3 encodings of the load instructions
//   RES_*          : ResultSrc encodings for the writeback result mux
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: purely combinational load-data aligner/extender.
//   raw      : word-aligned word read from data memory
//   off      : byte offset of the access (address bits [1:0])
//   funct3   : load width/sign selector
//   data     : aligned, sign- or zero-extended load value
//   misalign : access is not naturally aligned for its width
// Unused funct3 codes pass raw through with misalign low.
module load_align
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = rv32_pkg::XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = raw[{off, 3'b000} +: 8];
    half_lane = raw[{off[1], 4'b0000} +: 16];
  end

  always_comb begin
    data     = raw;
    misalign = 1'b0;
    case (funct3)
      LOAD_LB:  data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LOAD_LBU: data = {{(XLEN-8){1'b0}}, byte_lane};
      LOAD_LH: begin
        data     = {{(XLEN-16){half_lane[15]}}, half_lane};
        misalign = off[0];
      end
      LOAD_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_lane};
        misalign = off[0];
      end
      LOAD_LW: begin
        data     = raw;
        misalign = (off != 2'b00);
      end
      default: begin
        data     = raw;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register.
//   clk, rst_n          : clock, synchronous active-low reset
//   StallW, FlushW      : hold W registers / insert a bubble (flush wins)
//   *M inputs           : M-stage instruction fields and raw load word
//   *W outputs          : registered writeback operands and controls
//   MisalignW           : W instruction was a squashed misaligned load
//   InstRetW            : retired-instruction counter (wraps)
// All outputs are registers; there is no combinational input-to-output path.
module mem_wb_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN  = rv32_pkg::XLEN,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  RawReadDataM,
  input  logic [XLEN-1:0]  PC_Plus_4M,
  input  logic [1:0]       ResultSrcM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdM,
  input  logic [2:0]       Funct3M,
  output logic [XLEN-1:0]  ALUResultW,
  output logic [XLEN-1:0]  ReadDataW,
  output logic [XLEN-1:0]  PC_Plus_4W,
  output logic [1:0]       ResultSrcW,
  output logic             RegWriteW,
  output logic [4:0]       RdW,
  output logic             ValidW,
  output logic             MisalignW,
  output logic [CNT_W-1:0] InstRetW
);

  logic [XLEN-1:0] aligned_data;
  logic            align_fault;
  logic            load_misalign;
  logic            regwrite_q;
  logic            retire;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .raw      (RawReadDataM),
    .off      (ALUResultM[1:0]),
    .funct3   (Funct3M),
    .data     (aligned_data),
    .misalign (align_fault)
  );

  // Alignment faults only matter for instructions that actually select load data.
  always_comb begin
    load_misalign = (ResultSrcM == RES_MEM) && align_fault;
    regwrite_q    = RegWriteM && ValidM && (RdM != 5'd0) && !load_misalign;
    retire        = ValidM && !load_misalign;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PC_Plus_4W <= '0;
      ResultSrcW <= '0;
      RegWriteW  <= 1'b0;
      RdW        <= '0;
      ValidW     <= 1'b0;
      MisalignW  <= 1'b0;
      InstRetW   <= '0;
    end else if (FlushW) begin
      // Bubble: kill the controls only; data fields keep their last value.
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      MisalignW <= 1'b0;
    end else if (!StallW) begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= aligned_data;
      PC_Plus_4W <= PC_Plus_4M;
      ResultSrcW <= ResultSrcM;
      RegWriteW  <= regwrite_q;
      RdW        <= RdM;
      ValidW     <= ValidM;
      MisalignW  <= load_misalign;
      if (retire) begin
        InstRetW <= InstRetW + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] raw;
    logic [31:0] pc4;
    logic [1:0]  rsrc;
    logic        regw;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } in_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [1:0]  rsrc;
    logic        regw;
    logic [4:0]  rd;
    logic        valid;
    logic        mis;
    int unsigned instret;
    int unsigned instret4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, StallW, FlushW, ValidM, RegWriteM;
  logic [31:0] ALUResultM, RawReadDataM, PC_Plus_4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [2:0]  Funct3M;

  logic [31:0] ALUResultW, ReadDataW, PC_Plus_4W, InstRetW;
  logic [1:0]  ResultSrcW;
  logic        RegWriteW, ValidW, MisalignW;
  logic [4:0]  RdW;

  logic [31:0] d2_alu, d2_rdata, d2_pc4;
  logic [1:0]  d2_rsrc;
  logic        d2_regw, d2_valid, d2_mis;
  logic [4:0]  d2_rd;
  logic [3:0]  d2_instret;

  int checks   = 0;
  int failures = 0;

  exp_t expq[$];
  exp_t m;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .ALUResultM(ALUResultM), .RawReadDataM(RawReadDataM), .PC_Plus_4M(PC_Plus_4M),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .RdM(RdM), .Funct3M(Funct3M),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PC_Plus_4W(PC_Plus_4W),
    .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW), .RdW(RdW), .ValidW(ValidW),
    .MisalignW(MisalignW), .InstRetW(InstRetW)
  );

  mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .ALUResultM(ALUResultM), .RawReadDataM(RawReadDataM), .PC_Plus_4M(PC_Plus_4M),
    .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM), .RdM(RdM), .Funct3M(Funct3M),
    .ALUResultW(d2_alu), .ReadDataW(d2_rdata), .PC_Plus_4W(d2_pc4),
    .ResultSrcW(d2_rsrc), .RegWriteW(d2_regw), .RdW(d2_rd), .ValidW(d2_valid),
    .MisalignW(d2_mis), .InstRetW(d2_instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference load extraction using plain integer arithmetic on the word.
  function automatic logic [31:0] ref_load(input logic [31:0] raw, input int unsigned off,
                                           input logic [2:0] f3, output bit mis);
    longint r;
    longint v;
    r   = longint'(raw);
    mis = 1'b0;
    case (f3)
      3'd0: begin v = (r / (longint'(256) ** off)) % 256; if (v >= 128) v -= 256; end
      3'd4: v = (r / (longint'(256) ** off)) % 256;
      3'd1: begin
        v = (r / (longint'(65536) ** (off / 2))) % 65536;
        if (v >= 32768) v -= 65536;
        mis = (off % 2) == 1;
      end
      3'd5: begin
        v = (r / (longint'(65536) ** (off / 2))) % 65536;
        mis = (off % 2) == 1;
      end
      3'd2: begin v = r; mis = (off != 0); end
      default: v = r;
    endcase
    return v[31:0];
  endfunction

  task automatic cycle(input in_t i);
    logic [31:0] d;
    bit          amis;
    bit          mis;
    rst_n = i.rst_n; StallW = i.stall; FlushW = i.flush; ValidM = i.valid;
    ALUResultM = i.alu; RawReadDataM = i.raw; PC_Plus_4M = i.pc4;
    ResultSrcM = i.rsrc; RegWriteM = i.regw; RdM = i.rd; Funct3M = i.f3;
    if (!i.rst_n) begin
      m = '{default: 0};
    end else if (i.flush) begin
      m.valid = 0; m.regw = 0; m.mis = 0;
    end else if (!i.stall) begin
      d   = ref_load(i.raw, i.alu % 4, i.f3, amis);
      mis = (i.rsrc == 2'b01) && amis;
      m.alu = i.alu; m.rdata = d; m.pc4 = i.pc4; m.rsrc = i.rsrc; m.rd = i.rd;
      m.valid = i.valid; m.mis = mis;
      m.regw  = i.regw && i.valid && (i.rd != 0) && !mis;
      if (i.valid && !mis) begin
        m.instret  = m.instret + 1;
        m.instret4 = (m.instret4 + 1) % 16;
      end
    end
    expq.push_back(m);
    @(negedge clk);
  endtask

  task automatic cmp(input exp_t e, input string tag);
    chk({tag, "_alu"},     ALUResultW, e.alu);
    chk({tag, "_rdata"},   ReadDataW,  e.rdata);
    chk({tag, "_pc4"},     PC_Plus_4W, e.pc4);
    chk({tag, "_rsrc"},    {30'd0, ResultSrcW}, {30'd0, e.rsrc});
    chk({tag, "_regw"},    {31'd0, RegWriteW},  {31'd0, e.regw});
    chk({tag, "_rd"},      {27'd0, RdW},        {27'd0, e.rd});
    chk({tag, "_valid"},   {31'd0, ValidW},     {31'd0, e.valid});
    chk({tag, "_mis"},     {31'd0, MisalignW},  {31'd0, e.mis});
    chk({tag, "_instret"}, InstRetW, e.instret);
    chk({tag, "_instret4"}, {28'd0, d2_instret}, e.instret4);
  endtask

  // Monitor: compares after each edge, then again mid-cycle after inputs move.
  initial begin
    exp_t cur;
    bit   have;
    have = 0;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty actual=0 expected>0 t=%0t", $time);
      end else begin
        cur  = expq.pop_front();
        have = 1;
        cmp(cur, "post");
      end
      @(negedge clk);
      #1;
      if (have) cmp(cur, "hold");
    end
  end

  function automatic in_t idle();
    in_t t;
    t = '{rst_n: 1'b1, stall: 1'b0, flush: 1'b0, valid: 1'b0, alu: 32'd0, raw: 32'd0,
          pc4: 32'd0, rsrc: 2'b00, regw: 1'b0, rd: 5'd0, f3: 3'd0};
    return t;
  endfunction

  function automatic in_t rnd();
    in_t t;
    t.rst_n = ($urandom_range(0, 99) >= 2);
    t.stall = ($urandom_range(0, 99) < 20);
    t.flush = ($urandom_range(0, 99) < 10);
    t.valid = ($urandom_range(0, 99) < 80);
    t.alu   = $urandom;
    t.raw   = $urandom;
    t.pc4   = $urandom;
    t.rsrc  = 2'($urandom_range(0, 3));
    t.regw  = 1'($urandom_range(0, 1));
    t.rd    = 5'($urandom_range(0, 31));
    t.f3    = 3'($urandom_range(0, 7));
    return t;
  endfunction

  initial begin
    in_t t;
    m = '{default: 0};

    // Reset with every input high.
    t = '{rst_n: 1'b0, stall: 1'b1, flush: 1'b1, valid: 1'b1, alu: '1, raw: '1,
          pc4: '1, rsrc: 2'b11, regw: 1'b1, rd: 5'd31, f3: 3'd7};
    cycle(t);
    cycle(t);
    chk("rst_valid", {31'd0, ValidW}, 32'd0);
    chk("rst_instret", InstRetW, 32'd0);
    chk("rst_alu", ALUResultW, 32'd0);

    t = idle();
    t.valid = 1; t.alu = 32'h1234_5678; t.pc4 = 32'h0000_0104; t.regw = 1; t.rd = 5'd7;
    cycle(t);
    chk("release_alu", ALUResultW, 32'h1234_5678);
    chk("release_valid", {31'd0, ValidW}, 32'd1);

    // Load alignment.
    t = idle();
    t.valid = 1; t.regw = 1; t.rd = 5'd3; t.rsrc = 2'b01; t.raw = 32'h80FF_7F01;
    t.alu = 32'h1003; t.f3 = 3'b000;
    cycle(t);
    chk("lb_off3", ReadDataW, 32'hFFFF_FF80);
    t.f3 = 3'b100;
    cycle(t);
    chk("lbu_off3", ReadDataW, 32'h0000_0080);
    t.f3 = 3'b001; t.alu = 32'h1002;
    cycle(t);
    chk("lh_off2", ReadDataW, 32'hFFFF_80FF);

    // Misaligned word load.
    t.f3 = 3'b010; t.alu = 32'h1002; t.rd = 5'd5;
    cycle(t);
    chk("lw_mis_flag", {31'd0, MisalignW}, 32'd1);
    chk("lw_mis_regw", {31'd0, RegWriteW}, 32'd0);
    chk("lw_mis_valid", {31'd0, ValidW}, 32'd1);

    // Write to x0 still retires.
    t = idle();
    t.valid = 1; t.regw = 1; t.rd = 5'd0; t.rsrc = 2'b00; t.alu = 32'h55;
    cycle(t);
    chk("x0_regw", {31'd0, RegWriteW}, 32'd0);

    // Stall while inputs change, then stall+flush.
    t = idle();
    t.valid = 1; t.regw = 1; t.rd = 5'd9; t.alu = 32'hCAFE_0000; t.pc4 = 32'h200;
    cycle(t);
    for (int i = 0; i < 3; i++) begin
      t = rnd();
      t.rst_n = 1; t.stall = 1; t.flush = 0;
      cycle(t);
    end
    chk("stall_alu", ALUResultW, 32'hCAFE_0000);
    t.flush = 1; t.stall = 1;
    cycle(t);
    chk("flush_valid", {31'd0, ValidW}, 32'd0);
    chk("flush_regw", {31'd0, RegWriteW}, 32'd0);
    chk("flush_alu_hold", ALUResultW, 32'hCAFE_0000);

    // Counter wrap on the narrow instance.
    t = idle();
    t.rst_n = 0;
    cycle(t);
    t = idle();
    t.valid = 1;
    for (int i = 0; i < 16; i++) cycle(t);
    chk("wrap_instret4", {28'd0, d2_instret}, 32'd0);
    chk("wrap_instret", InstRetW, 32'd16);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) cycle(rnd());

    #2;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
